// File: rtl/types_pkg.sv
// Shared types for the DRAM FIFO writer and the store drain: the 100-bit
// FIFO entry layout, the writer state encoding and the tile address stride.
package types_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int ROW_W     = 2;
    localparam int NUM_FIFOS = 4;
    localparam int ENTRY_W   = 100;

    // Byte distance between consecutive tile base addresses (4 rows x 8 bytes).
    localparam logic [ADDR_W-1:0] STRIDE = 32'd32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        rsvd;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    function automatic entry_t pack_entry(input logic [ADDR_W-1:0] addr,
                                          input logic [ROW_W-1:0]  row,
                                          input logic [DATA_W-1:0] data);
        entry_t e;
        e.addr = addr;
        e.rsvd = 2'b00;
        e.row  = row;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/dramfifo_writer.sv
// Steers result rows of one tile into one of four DRAM FIFOs, rotating slots per tile.
// Optional stall counter output enabled by defining DRAMFIFO_WRITER_PERF_EN.
module dramfifo_writer
    import types_pkg::*;
#(
    parameter int NUM_ROWS = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_base_addr,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [DATA_W-1:0]    row_data,
    output logic                 dramFIFO0_WEN,
    output logic [ENTRY_W-1:0]   dramFIFO0_wdata,
    input  logic                 dramFIFO0_full,
    output logic                 dramFIFO1_WEN,
    output logic [ENTRY_W-1:0]   dramFIFO1_wdata,
    input  logic                 dramFIFO1_full,
    output logic                 dramFIFO2_WEN,
    output logic [ENTRY_W-1:0]   dramFIFO2_wdata,
    input  logic                 dramFIFO2_full,
    output logic                 dramFIFO3_WEN,
    output logic [ENTRY_W-1:0]   dramFIFO3_wdata,
    input  logic                 dramFIFO3_full,
    output logic                 tile_done,
    output logic                 busy
`ifdef DRAMFIFO_WRITER_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    state_t                 state_q, state_d;
    logic [1:0]             slot_ptr_q;
    logic [1:0]             cur_slot_q;
    logic [ROW_W-1:0]       row_cnt_q;
    logic [ADDR_W-1:0]      addr_q;

    logic [NUM_FIFOS-1:0]   full_vec;
    logic [NUM_FIFOS-1:0]   wen_vec;
    logic                   sel_full;
    logic                   wr_fire;
    logic                   last_row;
    entry_t                 entry;

    assign full_vec = {dramFIFO3_full, dramFIFO2_full, dramFIFO1_full, dramFIFO0_full};
    assign sel_full = full_vec[cur_slot_q];
    assign last_row = (row_cnt_q == ROW_W'(NUM_ROWS - 1));

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        row_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A reset cycle must not push a row of the abandoned tile.
                row_ready = ~sel_full & ~nRST;
                if (row_valid && row_ready && last_row) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_fire   = row_valid & row_ready;
    assign wen_vec   = wr_fire ? (NUM_FIFOS'(1) << cur_slot_q) : '0;
    assign tile_done = wr_fire & last_row;
    assign busy      = (state_q == ST_WRITE);
    assign entry     = pack_entry(addr_q, row_cnt_q, row_data);

    assign dramFIFO0_WEN   = wen_vec[0];
    assign dramFIFO1_WEN   = wen_vec[1];
    assign dramFIFO2_WEN   = wen_vec[2];
    assign dramFIFO3_WEN   = wen_vec[3];
    assign dramFIFO0_wdata = wen_vec[0] ? entry : '0;
    assign dramFIFO1_wdata = wen_vec[1] ? entry : '0;
    assign dramFIFO2_wdata = wen_vec[2] ? entry : '0;
    assign dramFIFO3_wdata = wen_vec[3] ? entry : '0;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= ST_IDLE;
            slot_ptr_q <= 2'd0;
            cur_slot_q <= 2'd0;
            row_cnt_q  <= '0;
            addr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                addr_q     <= req_base_addr;
                cur_slot_q <= slot_ptr_q;
                row_cnt_q  <= '0;
            end
            if (wr_fire) begin
                row_cnt_q <= row_cnt_q + ROW_W'(1);
                if (last_row) begin
                    slot_ptr_q <= slot_ptr_q + 2'd1;
                end
            end
        end
    end

`ifdef DRAMFIFO_WRITER_PERF_EN
    always_ff @(posedge CLK) begin
        if (nRST) begin
            stall_cycles <= '0;
        end else if (state_q == ST_WRITE && row_valid && sel_full && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dramfifo_writer.md
DRAMFIFO_WRITER -- requirements
Module: dramfifo_writer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, meaning rows per output tile (fixed at 4; row index field is 2 bits).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, synchronous, active-high (asserted = 1 resets on the next CLK edge).
REQ-004 SHALL have ports req_valid in 1 / req_ready out 1: tile store request handshake.
REQ-005 SHALL have port req_base_addr  in  32  DRAM base address of the tile.
REQ-006 SHALL have ports row_valid in 1 / row_ready out 1: result-row handshake from the array drain.
REQ-007 SHALL have port row_data  in  64  one row of four FP16 results.
REQ-008 SHALL have ports dramFIFOk_WEN out 1, dramFIFOk_wdata out 100, dramFIFOk_full in 1, for k = 0..3.
REQ-009 SHALL have port tile_done  out  1  one-cycle pulse when a tile's last row is written.
REQ-010 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pack each entry as wdata[99:68] = base address, [67:66] = 2'b00, [65:64] = row index, [63:0] = row data.
REQ-012 SHALL implement states IDLE and WRITE.
REQ-013 In IDLE: req_ready = 1, row_ready = 0; on req_valid, latch base address and the current slot pointer, clear row counter, go to WRITE.
REQ-014 In WRITE: req_ready = 0; row_ready = ~dramFIFO[slot]_full.
REQ-015 On row_valid && row_ready: same-cycle dramFIFO[slot]_WEN = 1, wdata packed with row index = row counter; counter increments.
REQ-016 Only the FIFO selected by the latched slot SHALL ever see WEN = 1; all other WEN = 0, and all wdata = 0 when no write occurs.
REQ-017 When a row is written with counter = NUM_ROWS-1: pulse tile_done, advance slot pointer mod 4 (3 wraps to 0), return to IDLE.
REQ-018 The selected FIFO full SHALL hold row_ready = 0 with no WEN and no counter change; resume the cycle full deasserts.
REQ-019 A req_valid arriving in WRITE SHALL be ignored (not latched) until IDLE; row_valid in IDLE SHALL be ignored.
REQ-020 Throughput SHALL be one row per cycle with no full; a tile completes in 1 + NUM_ROWS cycles minimum (request cycle plus 4 row cycles).
REQ-021 Back-to-back tiles: IDLE lasts exactly one cycle when req_valid is already high.

Reset
REQ-022 On nRST = 1: state = IDLE, slot pointer = 0, row counter = 0, latched address = 0, all WEN = 0, tile_done = 0, busy = 0.
REQ-023 Reset during WRITE SHALL abandon the partial tile; rows already pushed remain in the FIFOs, and no further WEN is issued.

Configuration
REQ-024 Macro DRAMFIFO_WRITER_PERF_EN: when defined, add output stall_cycles[31:0], which counts cycles in WRITE with row_valid = 1 and selected FIFO full; it saturates at all-ones and clears on reset.
REQ-025 Without DRAMFIFO_WRITER_PERF_EN, the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-026 types_pkg SHALL hold the 100-bit entry typedef (addr, rsvd, row, data fields), the state enum, and STRIDE (shared with the store drain).
REQ-027 The block SHALL be a single module with no sub-module; entry packing is a package function.

Verification
REQ-028 Reset then req base 0x0000_1000, rows A0..A3 back-to-back -> FIFO0 gets 4 WEN, rows 0..3, addr 0x1000 each, tile_done at the fourth write.
REQ-029 Five consecutive tiles -> slots 0,1,2,3,0; fifth tile's WEN on FIFO0 only.
REQ-030 dramFIFO1_full high for 3 cycles during tile 2 row 1 -> row_ready 0 for 3 cycles, no WEN, then row 1 written; PERF_EN: stall_cycles = 3.
REQ-031 req_valid held high during WRITE with base 0x2000 -> not accepted until after tile_done; next tile's address is 0x2000.
REQ-032 nRST asserted after row 1 written -> no further WEN, slot pointer 0, busy 0, next request targets FIFO0 starting row 0.
